hrange_rep: RTL and testbench

//   Parametrised successor to the generated range generator: yields base, base+step, ...

---
 rtl/hrange_rep.sv | 106 ++++++++++
 tb/tb_hrange_rep.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hrange_rep.sv
// Range generator: emits base, base+step, ... while strictly before limit, each value
// REPEAT times, on a ready/valid/done interface with overflow-safe termination.
module hrange_rep #(
    parameter int WIDTH  = 32,
    parameter int REPEAT = 2,
    parameter int REP_W  = $clog2(REPEAT + 1)
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             _ready,
    output logic             _valid,
    output logic             _done,
    output logic [WIDTH-1:0] _0,
    output logic [REP_W-1:0] _1
);

    typedef enum logic {StDone, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   nxt;
    logic             ovf;

    // A zero step never satisfies the condition, so it terminates immediately.
    function automatic logic cond_ok(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] lim,
                                     input logic signed [WIDTH-1:0] stp);
        if (stp > 0) return x < lim;
        if (stp < 0) return x > lim;
        return 1'b0;
    endfunction

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rep_d   = rep_q;
        lim_d   = lim_q;
        step_d  = step_q;
        valid_d = valid_q;
        done_d  = done_q;
        // Sign-extended sum: overflow shows as disagreement of the top two bits.
        nxt     = {val_q[WIDTH-1], val_q} + {step_q[WIDTH-1], step_q};
        ovf     = nxt[WIDTH] ^ nxt[WIDTH-1];

        if (_start) begin
            lim_d  = limit;
            step_d = step;
            val_d  = base;
            rep_d  = '0;
            if (cond_ok(base, limit, step)) begin
                state_d = StRun;
                valid_d = 1'b1;
                done_d  = 1'b0;
            end else begin
                state_d = StDone;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end else if (_reset) begin
            state_d = StDone;
            val_d   = '0;
            rep_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
        end else if (state_q == StRun && (_ready || !valid_q)) begin
            if (int'(rep_q) < REPEAT - 1) begin
                rep_d   = rep_q + REP_W'(1);
                valid_d = 1'b1;
            end else if (ovf || !cond_ok(nxt[WIDTH-1:0], lim_q, step_q)) begin
                state_d = StDone;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                val_d   = nxt[WIDTH-1:0];
                rep_d   = '0;
                valid_d = 1'b1;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge _clock) begin
        state_q <= state_d;
        val_q   <= val_d;
        rep_q   <= rep_d;
        lim_q   <= lim_d;
        step_q  <= step_d;
        valid_q <= valid_d;
        done_q  <= done_d;
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _0     = val_q;
    assign _1     = rep_q;

endmodule

// File: tb/tb_hrange_rep.sv
// Directed bench for hrange_rep: three instances cover REPEAT=2, REPEAT=1 and 8-bit overflow.
module tb_hrange_rep;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Instance A: WIDTH=32, REPEAT=2
    logic        a_start, a_ready, a_valid, a_done;
    logic [31:0] a_base, a_limit, a_step, a_o0;
    logic [1:0]  a_o1;
    // Instance B: WIDTH=32, REPEAT=1
    logic        b_start, b_ready, b_valid, b_done;
    logic [31:0] b_base, b_limit, b_step, b_o0;
    logic [0:0]  b_o1;
    // Instance C: WIDTH=8, REPEAT=1
    logic        c_start, c_ready, c_valid, c_done;
    logic [7:0]  c_base, c_limit, c_step, c_o0;
    logic [0:0]  c_o1;

    hrange_rep #(.WIDTH(32), .REPEAT(2)) u_a (
        ._clock(clk), ._reset(rst), ._start(a_start), .base(a_base), .limit(a_limit),
        .step(a_step), ._ready(a_ready), ._valid(a_valid), ._done(a_done), ._0(a_o0), ._1(a_o1)
    );
    hrange_rep #(.WIDTH(32), .REPEAT(1)) u_b (
        ._clock(clk), ._reset(rst), ._start(b_start), .base(b_base), .limit(b_limit),
        .step(b_step), ._ready(b_ready), ._valid(b_valid), ._done(b_done), ._0(b_o0), ._1(b_o1)
    );
    hrange_rep #(.WIDTH(8), .REPEAT(1)) u_c (
        ._clock(clk), ._reset(rst), ._start(c_start), .base(c_base), .limit(c_limit),
        .step(c_step), ._ready(c_ready), ._valid(c_valid), ._done(c_done), ._0(c_o0), ._1(c_o1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed {valid, done, value, rep} for instance A.
    function automatic logic [63:0] pa(input logic v, input logic d, input int val,
                                       input int rep);
        return {28'd0, v, d, 32'(val), 2'(rep)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_start = 0; a_ready = 1; a_base = 0; a_limit = 0; a_step = 0;
        b_start = 0; b_ready = 1; b_base = 0; b_limit = 0; b_step = 0;
        c_start = 0; c_ready = 1; c_base = 0; c_limit = 0; c_step = 0;
        tick();
        tick();
        chk("reset_a", {a_valid, a_done, a_o0, a_o1}, pa(0, 1, 0, 0));
        chk("reset_b", {b_valid, b_done, b_o0, b_o1}, {1'b0, 1'b1, 32'd0, 1'b0});
        chk("reset_c", {c_valid, c_done, c_o0, c_o1}, {1'b0, 1'b1, 8'd0, 1'b0});
        rst = 1'b0;

        // Test 1: 0..8 step 2, each value twice, full throughput
        a_base = 0; a_limit = 10; a_step = 2; a_ready = 1; a_start = 1;
        tick();
        a_start = 0;
        chk("t1_first", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 0, 0));
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("t1_out%0d", k), {a_valid, a_done, a_o0, a_o1},
                pa(1, 0, (k / 2) * 2, k % 2));
        end
        tick();
        chk("t1_done", {a_valid, a_done, a_o0, a_o1}, pa(0, 1, 8, 1));

        // Test 3: empty range, then zero step
        a_base = 10; a_limit = 10; a_step = 1; a_start = 1;
        tick();
        a_start = 0;
        chk("t3_empty", {62'd0, a_valid, a_done}, 64'b01);
        tick();
        chk("t3_empty_hold", {62'd0, a_valid, a_done}, 64'b01);
        a_base = 0; a_limit = 10; a_step = 0; a_start = 1;
        tick();
        a_start = 0;
        chk("t3_zero", {62'd0, a_valid, a_done}, 64'b01);
        tick();
        chk("t3_zero_hold", {62'd0, a_valid, a_done}, 64'b01);

        // Test 4: backpressure on value 2, rep 0
        a_base = 0; a_limit = 10; a_step = 2; a_start = 1;
        tick();
        a_start = 0;
        chk("t4_0", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 0, 0));
        tick();
        chk("t4_1", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 0, 1));
        tick();
        chk("t4_2", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 2, 0));
        a_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t4_stall%0d", k), {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 2, 0));
        end
        a_ready = 1;
        for (int k = 3; k < 10; k++) begin
            tick();
            chk($sformatf("t4_out%0d", k), {a_valid, a_done, a_o0, a_o1},
                pa(1, 0, (k / 2) * 2, k % 2));
        end
        tick();
        chk("t4_done", {62'd0, a_valid, a_done}, 64'b01);

        // Test 6: mid-stream reset, then start overriding reset
        a_base = 0; a_start = 1;
        tick();
        a_start = 0;
        tick();
        tick();
        chk("t6_pre", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 2, 0));
        rst = 1;
        tick();
        chk("t6_reset", {62'd0, a_valid, a_done}, 64'b01);
        a_base = 4; a_start = 1;
        tick();
        a_start = 0; rst = 0;
        chk("t6_restart", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 4, 0));
        tick();
        chk("t6_r1", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 4, 1));
        tick();
        chk("t6_r2", {a_valid, a_done, a_o0, a_o1}, pa(1, 0, 6, 0));

        // Test 2: negative step, REPEAT=1
        b_base = 5; b_limit = 0; b_step = -32'sd2; b_start = 1;
        tick();
        b_start = 0;
        chk("t2_5", {b_valid, b_done, b_o0, b_o1}, {1'b1, 1'b0, 32'd5, 1'b0});
        tick();
        chk("t2_3", {b_valid, b_done, b_o0, b_o1}, {1'b1, 1'b0, 32'd3, 1'b0});
        tick();
        chk("t2_1", {b_valid, b_done, b_o0, b_o1}, {1'b1, 1'b0, 32'd1, 1'b0});
        tick();
        chk("t2_done", {62'd0, b_valid, b_done}, 64'b01);

        // Test 5: 8-bit overflow must terminate rather than wrap to -126
        c_base = 8'd120; c_limit = 8'd127; c_step = 8'd5; c_start = 1;
        tick();
        c_start = 0;
        chk("t5_120", {c_valid, c_done, c_o0, c_o1}, {1'b1, 1'b0, 8'd120, 1'b0});
        tick();
        chk("t5_125", {c_valid, c_done, c_o0, c_o1}, {1'b1, 1'b0, 8'd125, 1'b0});
        tick();
        chk("t5_done", {62'd0, c_valid, c_done}, 64'b01);
        tick();
        chk("t5_hold", {62'd0, c_valid, c_done}, 64'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
